// File: rtl/fmap_stream_reader.sv
// Raster-order feature-map reader: issues frame-RAM reads, absorbs the 1-cycle
// read latency and streams one all-channel pixel vector per cycle over ready/valid.
module fmap_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_SIZE   = 222,
    parameter int NUM_CHANNELS = 64,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_rd_data,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] pixel_out,
    output logic                               pixel_valid,
    input  logic                               pixel_ready,
    output logic                               row_last,
    output logic                               frame_last,
    output logic                               busy,
    output logic                               done
);

    localparam int NUM_PIX = IMAGE_SIZE * IMAGE_SIZE;
    localparam int COL_W   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int RD_LAT  = 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMAGE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    typedef struct packed {
        logic row_last;
        logic frame_last;
    } tag_t;

    state_t                                    state;
    logic [ADDR_WIDTH-1:0]                     rd_addr;
    logic [COL_W-1:0]                          rd_col;

    logic [RD_LAT:0]                           vld_pipe;
    logic [RD_LAT:1]                           vld_q;
    tag_t [RD_LAT:0]                           tag_pipe;
    tag_t [RD_LAT:1]                           tag_q;
    tag_t                                      tag_new;

    logic [1:0]                                fifo_count;
    logic                                      wr_ptr;
    logic                                      rd_ptr;
    tag_t [1:0]                                fifo_tag;
    tag_t                                      head_tag;

    logic                                      issue;
    logic                                      push;
    logic                                      pop;
    logic [2:0]                                occupancy;

    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   rd_lane;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   out_lane;

    assign pixel_valid = (fifo_count != 2'd0);
    assign pop         = pixel_valid & pixel_ready;
    assign push        = vld_pipe[RD_LAT];

    // Slots already committed (stored + in flight) once this cycle's pop retires.
    assign occupancy = {1'b0, fifo_count} + {2'b00, vld_pipe[RD_LAT]} - {2'b00, pop};
    assign issue     = (state == STREAM) && (occupancy < 3'd2);

    assign mem_rd_en = issue;
    assign mem_addr  = issue ? rd_addr : '0;

    always_comb begin
        tag_new            = '0;
        tag_new.row_last   = (rd_col == LAST_COL);
        tag_new.frame_last = (rd_addr == LAST_ADDR);
    end

    always_comb begin
        vld_pipe = {vld_q, issue};
        tag_pipe = {tag_q, tag_new};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LAT-1:0];
            tag_q <= tag_pipe[RD_LAT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_addr <= '0;
            rd_col  <= '0;
        end else begin
            done <= 1'b0;
            if (issue) begin
                if (rd_addr != LAST_ADDR)
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + COL_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                        rd_col  <= '0;
                    end
                end
                STREAM: begin
                    if (issue && (rd_addr == LAST_ADDR))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && head_tag.frame_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output FIFO: pointers and flag tags here, per-lane data below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_tag   <= '0;
        end else begin
            if (push) begin
                fifo_tag[wr_ptr] <= tag_pipe[RD_LAT];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_tag   = fifo_tag[rd_ptr];
    assign row_last   = pixel_valid & head_tag.row_last;
    assign frame_last = pixel_valid & head_tag.frame_last;

    assign rd_lane   = mem_rd_data;
    assign pixel_out = out_lane;

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
        logic [1:0][DATA_WIDTH-1:0] slot;

        always_ff @(posedge clk) begin
            if (!rst_n)
                slot <= '0;
            else if (push)
                slot[wr_ptr] <= rd_lane[k];
        end

        assign out_lane[k] = slot[rd_ptr];
    end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Bench for fmap_stream_reader: small 4x4x2 frame with a pixel-index model, plus
// one full-size default-parameter frame streamed back to back.
module tb_fmap_stream_reader;

    localparam int DW = 8;
    localparam int IS = 4;
    localparam int NC = 2;
    localparam int AW = 4;
    localparam int NPIX = IS * IS;
    localparam int B_IS = 222;
    localparam int B_NPIX = B_IS * B_IS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, start, pixel_ready;
    logic            mem_rd_en, pixel_valid, row_last, frame_last, busy, done;
    logic [AW-1:0]   mem_addr;
    logic [NC*DW-1:0] mem_rd_data, pixel_out;

    logic            b_start, b_ready;
    logic            b_mem_rd_en, b_pixel_valid, b_row_last, b_frame_last, b_busy, b_done;
    logic [15:0]     b_mem_addr;
    logic [511:0]    b_mem_rd_data, b_pixel_out;

    fmap_stream_reader #(.DATA_WIDTH(DW), .IMAGE_SIZE(IS), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .row_last(row_last), .frame_last(frame_last),
        .busy(busy), .done(done));

    fmap_stream_reader dut_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr),
        .mem_rd_data(b_mem_rd_data), .pixel_out(b_pixel_out), .pixel_valid(b_pixel_valid),
        .pixel_ready(b_ready), .row_last(b_row_last), .frame_last(b_frame_last),
        .busy(b_busy), .done(b_done));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM models: small word[a] = {a+8'h80, a}; big lanes 0/1 carry the address bytes.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= {8'(mem_addr) + 8'h80, 8'(mem_addr)};
        if (b_mem_rd_en)
            for (int k = 0; k < 64; k++)
                b_mem_rd_data[k*8 +: 8] <= (k == 0) ? b_mem_addr[7:0] :
                                           (k == 1) ? b_mem_addr[15:8] : 8'(k);
    end

    function automatic logic [17:0] exp_vec(input int i);
        return {(i % IS) == IS - 1, i == NPIX - 1, 8'(i + 8'h80), 8'(i)};
    endfunction

    int          exp_idx = 0;
    int          rd_issued = 0;
    int          done_cnt = 0;
    bit          prev_stall = 0;
    logic [17:0] prev_out = '0;
    logic [15:0] rl_mask = '0;
    logic [15:0] last_rl = '0;
    logic [15:0] last_fl = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_idx = 0; rd_issued = 0; prev_stall = 0; rl_mask = '0;
        end else begin
            if (mem_rd_en) begin
                chk("mem_addr", 64'(mem_addr), 64'(rd_issued));
                rd_issued++;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(pixel_valid), 64'd1);
                chk("stall_hold", 64'({row_last, frame_last, pixel_out}), 64'(prev_out));
            end
            if (pixel_valid) begin
                chk("pixel_in_frame", 64'(exp_idx < NPIX), 64'd1);
                chk("pixel", 64'({row_last, frame_last, pixel_out}), 64'(exp_vec(exp_idx)));
                if (frame_last) last_fl = pixel_out;
                if (pixel_ready) begin
                    if (row_last) rl_mask[exp_idx[3:0]] = 1'b1;
                    exp_idx++;
                end
            end
            chk("fifo_space", 64'((rd_issued - exp_idx) <= 2), 64'd1);
            prev_stall = pixel_valid && !pixel_ready;
            prev_out   = {row_last, frame_last, pixel_out};
            if (done) begin
                done_cnt++;
                chk("done_pixels", 64'(exp_idx), 64'(NPIX));
                last_rl = rl_mask;
                exp_idx = 0; rd_issued = 0; rl_mask = '0;
            end
        end
    end

    int b_px = 0;
    bit b_started = 0, b_ended = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_px = 0; b_started = 0; b_ended = 0;
        end else begin
            if (b_pixel_valid) b_started = 1;
            if (b_started && !b_ended && b_px < B_NPIX) begin
                chk("big_no_bubble", 64'(b_pixel_valid), 64'd1);
                if (b_pixel_valid) begin
                    chk("big_pixel", 64'({b_row_last, b_frame_last, b_pixel_out[15:0]}),
                        64'({(b_px % B_IS) == B_IS - 1, b_px == B_NPIX - 1, 16'(b_px)}));
                    if (b_frame_last) b_ended = 1;
                    b_px++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, 64'({mem_rd_en, mem_addr, pixel_valid, pixel_out, row_last, frame_last, busy, done}), 64'd0);
    endtask

    // mode 0: ready=1; 1: ready 1,0,0,1 repeating; 3: ready=1 with stray start pulses
    task automatic run_frame(input int mode, input int budget, output int cyc);
        bit seen;
        int c;
        seen = 0; c = 0; cyc = -1;
        while (!seen && c < budget) begin
            pixel_ready = (mode == 1) ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            @(negedge clk); #1;
            if (mode == 3)
                start = (pixel_valid && (pixel_out[7:0] == 8'd5 || pixel_out[7:0] == 8'd15)) || done;
            if (done) begin
                seen = 1;
                cyc  = c;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            step();
            start = 1'b0;
            c++;
        end
        chk("frame_completed", 64'(seen), 64'd1);
        pixel_ready = 1'b1;
    endtask

    int cyc, d0;
    bit hit;

    initial begin
        rst_n = 1'b0; start = 1'b0; pixel_ready = 1'b1; b_start = 1'b0; b_ready = 1'b1;
        step(); step();
        @(negedge clk);
        chk_zero("reset_outputs");
        chk("big_reset", 64'({b_mem_rd_en, b_pixel_valid, b_busy, b_done}), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: latency, ordering, flags and done timing
        pulse_start();
        @(negedge clk);
        chk("t1_rd_en", 64'({mem_rd_en, mem_addr, busy, pixel_valid}), 64'({1'b1, 4'd0, 1'b1, 1'b0}));
        @(negedge clk);
        chk("t2_rd_en", 64'({mem_rd_en, mem_addr, pixel_valid}), 64'({1'b1, 4'd1, 1'b0}));
        @(negedge clk);
        chk("t3_first_px", 64'({pixel_valid, row_last, frame_last, pixel_out}), 64'({3'b100, 16'h8000}));
        step();
        run_frame(0, 60, cyc);
        chk("done_latency", 64'(cyc), 64'd15);
        chk("row_last_mask", 64'(last_rl), 64'h8888);
        chk("frame_last_px", 64'(last_fl), 64'h8F0F);
        @(negedge clk);
        chk("post_done", 64'({done, busy}), 64'd0);
        step();

        // 2: toggling back-pressure
        pulse_start();
        run_frame(1, 200, cyc);
        chk("t2_rows", 64'(last_rl), 64'h8888);
        step();

        // 3: long stall right after start
        pixel_ready = 1'b0;
        pulse_start();
        repeat (10) begin
            @(negedge clk);
            step();
        end
        @(negedge clk); #1;
        chk("stall_reads", 64'(rd_issued), 64'd2);
        chk("stall_px0", 64'({pixel_valid, pixel_out}), 64'({1'b1, 16'h8000}));
        step();
        pixel_ready = 1'b1;
        @(negedge clk);
        chk("release_px0", 64'(pixel_out), 64'h8000);
        step();
        @(negedge clk);
        chk("resume_px1", 64'(pixel_out), 64'h8101);
        step();
        run_frame(0, 60, cyc);
        step();

        // 4: start re-pulsed mid-frame, in drain and in the done cycle
        d0 = done_cnt;
        pulse_start();
        run_frame(3, 60, cyc);
        repeat (4) step();
        @(negedge clk);
        chk("restart_ignored", 64'({busy, mem_rd_en, pixel_valid}), 64'd0);
        chk("single_done", 64'(done_cnt - d0), 64'd1);
        step();

        // 5: reset mid-frame, then a fresh frame
        pulse_start();
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk); #1;
            if (pixel_valid && pixel_out[7:0] == 8'd9) hit = 1;
            else step();
        end
        chk("reached_px9", 64'(hit), 64'd1);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk_zero("midframe_reset");
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        @(negedge clk);
        chk("fresh_addr0", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 4'd0}));
        step();
        run_frame(0, 60, cyc);
        chk("fresh_rows", 64'(last_rl), 64'h8888);
        step();

        // 6: full default-size frame, back to back
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 50000 && !hit; c++) begin
            @(negedge clk); #1;
            if (b_done) hit = 1;
            step();
        end
        chk("big_done", 64'(hit), 64'd1);
        chk("big_count", 64'(b_px), 64'(B_NPIX));
        chk("big_frame_last", 64'(b_ended), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
